screen_draw_ctrl: RTL and testbench

Sequencer and arbiter for the full-screen image drawer. Accepts draw requests for the four 160x120 screens (board, red win, yellow win, tie) from the game FSM, grants exactly one at a time, and drives the drawer's one-hot select lines, `resetb`, `en_screenCycle` and the VGA `plot` strobe. A new screen starts only after the previous one has been fully plotted. Sits between the game-logic FSM and the `drawScreen` datapath / VGA adapter.

---
 rtl/screen_draw_ctrl_if.sv | 31 +++
 rtl/screen_draw_ctrl.sv | 148 ++++++++++++++
 tb/tb_screen_draw_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/screen_draw_ctrl_if.sv
// Request/select bundle between the game FSM and the screen draw sequencer.
interface screen_draw_ctrl_if;
  logic       req_board;
  logic       req_rwin;
  logic       req_ywin;
  logic       req_tie;
  logic       drawBoard;
  logic       drawRWin;
  logic       drawYWin;
  logic       gameTie;
  logic       resetb;
  logic       en_screenCycle;
  logic       plot;
  logic       busy;
  logic       done;
  logic [1:0] cur_sel;

  // Game-logic side: issues requests, observes drawer controls and status.
  modport master (
    output req_board, req_rwin, req_ywin, req_tie,
    input  drawBoard, drawRWin, drawYWin, gameTie,
    input  resetb, en_screenCycle, plot, busy, done, cur_sel
  );

  // Sequencer side.
  modport slave (
    input  req_board, req_rwin, req_ywin, req_tie,
    output drawBoard, drawRWin, drawYWin, gameTie,
    output resetb, en_screenCycle, plot, busy, done, cur_sel
  );
endinterface

// File: rtl/screen_draw_ctrl.sv
// Full-screen draw sequencer/arbiter: captures screen requests, grants one
// at a time (red > yellow > tie > board) and steps the drawer through
// clear, NPIX draw cycles and a PIPE-cycle drain before signalling done.
module screen_draw_ctrl #(
  parameter int NPIX = 19200,
  parameter int PIPE = 2
) (
  input logic              clk,
  input logic              resetn,
  screen_draw_ctrl_if.slave bus
);

  localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            armed;
  logic [3:0]      req_vec;
  logic [3:0]      pending;
  logic [3:0]      grant_clr;
  logic [1:0]      grant_sel;
  logic            grant;
  logic [1:0]      cur_sel;
  logic [14:0]     pix_cnt;
  logic            draw_last;
  logic [DW-1:0]   drain_cnt;
  logic            drain_last;
  logic [PIPE-1:0] plot_sr;

  // Bit index equals the cur_sel encoding: 0=board 1=red 2=yellow 3=tie.
  assign req_vec    = {bus.req_tie, bus.req_ywin, bus.req_rwin, bus.req_board};
  assign grant      = (state == S_IDLE) && (|pending);
  assign grant_clr  = grant ? (4'b0001 << grant_sel) : 4'b0000;
  assign draw_last  = (pix_cnt == 15'(NPIX - 1));
  assign drain_last = (drain_cnt == DW'(PIPE - 1));

  // Fixed-priority pick among pending screens.
  always_comb begin
    grant_sel = 2'd0;
    if (pending[1])      grant_sel = 2'd1;
    else if (pending[2]) grant_sel = 2'd2;
    else if (pending[3]) grant_sel = 2'd3;
    else                 grant_sel = 2'd0;
  end

  // Armed one edge after reset release so a request in the release cycle is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) armed <= 1'b0;
    else         armed <= 1'b1;
  end

  // Pending requests: a new pulse wins over the grant clear, so a re-request
  // of the screen being granted or drawn queues a redraw.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pending <= '0;
    else         pending <= (pending & ~grant_clr) | (armed ? req_vec : 4'b0000);
  end

  // Latch the granted screen; it stays as the last-drawn screen while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    cur_sel <= '0;
    else if (grant) cur_sel <= grant_sel;
  end

  // Pixel counter: cleared entering CLEAR, counts 0..NPIX-1 during DRAW.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                             pix_cnt <= '0;
    else if (grant)                          pix_cnt <= '0;
    else if (state == S_DRAW && !draw_last)  pix_cnt <= pix_cnt + 15'd1;
  end

  // Drain counter: cleared during DRAW, counts the PIPE cycles of DRAIN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 drain_cnt <= '0;
    else if (state == S_DRAW)    drain_cnt <= '0;
    else if (state == S_DRAIN)   drain_cnt <= drain_cnt + DW'(1);
  end

  // Plot strobe: DRAW indicator delayed PIPE cycles to align with drawer output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot_sr <= '0;
    end else begin
      plot_sr[0] <= (state == S_DRAW);
      for (int unsigned i = 1; i < PIPE; i++) plot_sr[i] <= plot_sr[i-1];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and drawer control decode.
  always_comb begin
    state_nxt          = state;
    bus.drawBoard      = 1'b0;
    bus.drawRWin       = 1'b0;
    bus.drawYWin       = 1'b0;
    bus.gameTie        = 1'b0;
    bus.resetb         = 1'b1;
    bus.en_screenCycle = 1'b0;
    bus.busy           = 1'b1;
    bus.done           = 1'b0;
    bus.plot           = plot_sr[PIPE-1];
    bus.cur_sel        = cur_sel;

    unique case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (grant) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        bus.resetb = 1'b0;
        state_nxt  = S_DRAW;
      end
      S_DRAW: begin
        bus.en_screenCycle = 1'b1;
        if (draw_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state == S_CLEAR || state == S_DRAW) begin
      bus.drawBoard = (cur_sel == 2'd0);
      bus.drawRWin  = (cur_sel == 2'd1);
      bus.drawYWin  = (cur_sel == 2'd2);
      bus.gameTie   = (cur_sel == 2'd3);
    end
  end

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Directed bench for screen_draw_ctrl: small-NPIX instance for sequencing
// and arbitration, default-size instance for full-screen counts.
module tb_screen_draw_ctrl;

  logic clk;
  logic resetn;

  screen_draw_ctrl_if ifa ();
  screen_draw_ctrl_if ifb ();

  screen_draw_ctrl #(.NPIX(16), .PIPE(2)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifa)
  );

  screen_draw_ctrl #(.NPIX(19200), .PIPE(2)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Monitors: cumulative event counts, sampled mid-cycle.
  int ncyc = 0;
  int plot_a = 0, en_a = 0, busy_a = 0, done_a = 0, clr_a = 0, oh_a = 0;
  int plot_b = 0, en_b = 0, busy_b = 0, done_b = 0;
  int order_q[$];
  int done_cyc[$];
  int clr_cyc[$];

  always @(negedge clk) begin
    ncyc++;
    if (ifa.plot)           plot_a++;
    if (ifa.en_screenCycle) en_a++;
    if (ifa.busy)           busy_a++;
    if (ifa.done) begin
      done_a++;
      done_cyc.push_back(ncyc);
    end
    if (!ifa.resetb) begin
      clr_a++;
      order_q.push_back(int'(ifa.cur_sel));
      clr_cyc.push_back(ncyc);
    end
    if (32'(ifa.drawBoard) + 32'(ifa.drawRWin) + 32'(ifa.drawYWin) + 32'(ifa.gameTie) > 1)
      oh_a++;
    if (ifb.plot)           plot_b++;
    if (ifb.en_screenCycle) en_b++;
    if (ifb.busy)           busy_b++;
    if (ifb.done)           done_b++;
  end

  typedef struct {
    int          cyc;
    logic [3:0]  req;
    logic        chk;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [10:0] E(input logic [3:0] s, input logic rb, en, pl, bz, dn,
                                    input logic [1:0] cs);
    return {s, rb, en, pl, bz, dn, cs};
  endfunction

  function automatic logic [10:0] outs_a();
    return {ifa.gameTie, ifa.drawYWin, ifa.drawRWin, ifa.drawBoard, ifa.resetb,
            ifa.en_screenCycle, ifa.plot, ifa.busy, ifa.done, ifa.cur_sel};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] r);
    ifa.req_board = r[0];
    ifa.req_rwin  = r[1];
    ifa.req_ywin  = r[2];
    ifa.req_tie   = r[3];
  endtask

  task automatic pulse(input logic [3:0] r);
    set_req(r);
    @(negedge clk);
    set_req(4'b0000);
  endtask

  // Leaves the bench at the negedge of the release cycle (cycle 0).
  task automatic do_reset();
    set_req(4'b0000);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int s_ord, s_done, s_plot, s_en, s_clr, s_oh, s_busy;
    int s_cc, s_dc;

    resetn = 1'b0;
    set_req(4'b0000);
    ifb.req_board = 1'b0;
    ifb.req_rwin  = 1'b0;
    ifb.req_ywin  = 1'b0;
    ifb.req_tie   = 1'b0;

    // Single board request at cycle 10; red pulse in the release cycle must be dropped.
    tbl[0]  = '{0,  4'b0010, 1'b1, E(4'b0000, 1, 0, 0, 0, 0, 2'd0)};
    tbl[1]  = '{10, 4'b0001, 1'b1, E(4'b0000, 1, 0, 0, 0, 0, 2'd0)};
    tbl[2]  = '{11, 4'b0000, 1'b1, E(4'b0000, 1, 0, 0, 0, 0, 2'd0)};
    tbl[3]  = '{12, 4'b0000, 1'b1, E(4'b0001, 0, 0, 0, 1, 0, 2'd0)};
    tbl[4]  = '{13, 4'b0000, 1'b1, E(4'b0001, 1, 1, 0, 1, 0, 2'd0)};
    tbl[5]  = '{14, 4'b0000, 1'b1, E(4'b0001, 1, 1, 0, 1, 0, 2'd0)};
    tbl[6]  = '{15, 4'b0000, 1'b1, E(4'b0001, 1, 1, 1, 1, 0, 2'd0)};
    tbl[7]  = '{28, 4'b0000, 1'b1, E(4'b0001, 1, 1, 1, 1, 0, 2'd0)};
    tbl[8]  = '{29, 4'b0000, 1'b1, E(4'b0000, 1, 0, 1, 1, 0, 2'd0)};
    tbl[9]  = '{30, 4'b0000, 1'b1, E(4'b0000, 1, 0, 1, 1, 0, 2'd0)};
    tbl[10] = '{31, 4'b0000, 1'b1, E(4'b0000, 1, 0, 0, 1, 1, 2'd0)};
    tbl[11] = '{32, 4'b0000, 1'b1, E(4'b0000, 1, 0, 0, 0, 0, 2'd0)};
    tbl[12] = '{33, 4'b0000, 1'b1, E(4'b0000, 1, 0, 0, 0, 0, 2'd0)};

    // --- Table scenario: single board draw
    do_reset();
    #1;
    s_plot = plot_a; s_en = en_a; s_clr = clr_a; s_done = done_a; s_busy = busy_a;
    for (int c = 0; c <= 40; c++) begin
      logic [3:0] r;
      r = 4'b0000;
      for (int k = 0; k < 13; k++) begin
        if (tbl[k].cyc == c) begin
          if (tbl[k].chk) check($sformatf("tbl_cyc%0d", c), 32'(outs_a()), 32'(tbl[k].exp));
          r = tbl[k].req;
        end
      end
      set_req(r);
      @(negedge clk);
    end
    #1;
    check("single_plot_cnt",  plot_a - s_plot, 16);
    check("single_en_cnt",    en_a - s_en, 16);
    check("single_clr_cnt",   clr_a - s_clr, 1);
    check("single_done_cnt",  done_a - s_done, 1);
    check("single_busy_len",  busy_a - s_busy, 20);

    // --- Simultaneous board+tie+red: served red, tie, board
    do_reset();
    #1;
    s_ord = order_q.size(); s_done = done_a; s_plot = plot_a; s_oh = oh_a;
    s_cc = clr_cyc.size(); s_dc = done_cyc.size();
    repeat (5) @(negedge clk);
    pulse(4'b1011);
    repeat (100) @(negedge clk);
    #1;
    check("multi_done_cnt", done_a - s_done, 3);
    check("multi_plot_cnt", plot_a - s_plot, 48);
    check("multi_onehot",   oh_a - s_oh, 0);
    check("multi_grants",   order_q.size() - s_ord, 3);
    if (order_q.size() - s_ord >= 3 && done_cyc.size() - s_dc >= 2 && clr_cyc.size() - s_cc >= 3) begin
      check("multi_order0", order_q[s_ord],   1);
      check("multi_order1", order_q[s_ord+1], 3);
      check("multi_order2", order_q[s_ord+2], 0);
      check("multi_gap0",   clr_cyc[s_cc+1] - done_cyc[s_dc],   2);
      check("multi_gap1",   clr_cyc[s_cc+2] - done_cyc[s_dc+1], 2);
    end

    // --- Yellow request at board pixel 5
    do_reset();
    #1;
    s_ord = order_q.size(); s_done = done_a; s_plot = plot_a;
    repeat (5) @(negedge clk);
    pulse(4'b0001);             // cycle 5, now at 6
    repeat (7) @(negedge clk);  // cycle 13 = DRAW pixel 5
    pulse(4'b0100);             // now at 14
    repeat (12) @(negedge clk); // cycle 26
    check("mid_board_done", {30'd0, ifa.done, ifa.busy}, 32'b11);
    check("mid_board_sel",  32'(ifa.cur_sel), 0);
    repeat (2) @(negedge clk);  // cycle 28
    check("mid_y_clear", {29'd0, ifa.resetb, ifa.drawYWin, ifa.drawBoard}, 32'b010);
    check("mid_y_sel",   32'(ifa.cur_sel), 2);
    repeat (40) @(negedge clk);
    #1;
    check("mid_done_cnt", done_a - s_done, 2);
    check("mid_plot_cnt", plot_a - s_plot, 32);

    // --- Board re-request mid-draw: drawn twice
    do_reset();
    #1;
    s_ord = order_q.size(); s_done = done_a; s_plot = plot_a;
    repeat (5) @(negedge clk);
    pulse(4'b0001);
    repeat (7) @(negedge clk);
    pulse(4'b0001);
    repeat (60) @(negedge clk);
    #1;
    check("redraw_done_cnt", done_a - s_done, 2);
    check("redraw_plot_cnt", plot_a - s_plot, 32);
    check("redraw_grants",   order_q.size() - s_ord, 2);
    if (order_q.size() - s_ord >= 2)
      check("redraw_order", order_q[s_ord] + order_q[s_ord+1], 0);

    // --- Asynchronous reset at DRAW pixel 8
    do_reset();
    #1;
    s_done = done_a;
    repeat (5) @(negedge clk);
    pulse(4'b0001);             // now at 6
    repeat (10) @(negedge clk); // cycle 16 = pixel 8
    check("abort_pre_busy", 32'(ifa.busy), 1);
    #2 resetn = 1'b0;
    #1;
    check("abort_outs", 32'(outs_a()), 32'(E(4'b0000, 1, 0, 0, 0, 0, 2'd0)));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    s_busy = busy_a;
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_done", done_a - s_done, 0);
    check("abort_idle",    busy_a - s_busy, 0);

    // --- Default-size instance, single tie request
    s_plot = plot_b; s_en = en_b; s_busy = busy_b; s_done = done_b;
    ifb.req_tie = 1'b1;
    @(negedge clk);
    ifb.req_tie = 1'b0;
    repeat (19220) @(negedge clk);
    #1;
    check("full_plot_cnt", plot_b - s_plot, 19200);
    check("full_en_cnt",   en_b - s_en, 19200);
    check("full_busy_len", busy_b - s_busy, 19204);
    check("full_done_cnt", done_b - s_done, 1);
    check("full_cur_sel",  32'(ifb.cur_sel), 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
